// File: rtl/dcache_word_reader.sv
// dcache_word_reader
//
// Load initiator for one dcache request port, on the core side of the cache-controller
// protocol. It reads num_words_i consecutive 64-bit words starting at start_addr_i, using
// the split index/tag request handshake, and presents the returned words on a valid/ready
// stream through a small elastic buffer.
//
// Build option: define DCACHE_WORD_READER_PERF_EN to enable the stall_cnt_o counter.
// When it is undefined, stall_cnt_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              start pulse, accepted only while busy_o = 0
//   start_addr_i         first word address (56-bit, 8-byte aligned)
//   num_words_i          number of words to read (0 = complete immediately)
//   abort_i              abandon the current run
//   busy_o               run in progress (through the done_o cycle)
//   done_o / aborted_o   end-of-run pulse; aborted_o qualifies done_o
//   err_o                pulse when a start is rejected as misaligned
//   address_index_o, data_req_o, data_gnt_i            index phase
//   address_tag_o, tag_valid_o, kill_req_o             tag phase
//   data_rvalid_i, data_rdata_i                        read response
//   data_we_o, data_be_o, data_size_o, data_wdata_o    constant read attributes
//   out_valid_o, out_data_o, out_ready_i               output stream
//   stall_cnt_o          saturating stall-cycle counter (optional)
module dcache_word_reader #(
  parameter int unsigned INDEX_W    = 12,
  parameter int unsigned TAG_W      = 44,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [INDEX_W+TAG_W-1:0]   start_addr_i,
  input  logic [CNT_W-1:0]           num_words_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       aborted_o,
  output logic [INDEX_W-1:0]         address_index_o,
  output logic [TAG_W-1:0]           address_tag_o,
  output logic                       data_req_o,
  output logic                       data_we_o,
  output logic [7:0]                 data_be_o,
  output logic [1:0]                 data_size_o,
  output logic [63:0]                data_wdata_o,
  output logic                       kill_req_o,
  output logic                       tag_valid_o,
  input  logic                       data_gnt_i,
  input  logic                       data_rvalid_i,
  input  logic [63:0]                data_rdata_i,
  output logic                       out_valid_o,
  output logic [63:0]                out_data_o,
  input  logic                       out_ready_i,
  output logic [31:0]                stall_cnt_o
);

  localparam int unsigned AddrW = INDEX_W + TAG_W;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StTag,
    StWait,
    StDrainKill
  } state_e;

  // FSM state and registered outputs
  state_e               r_state;
  logic [AddrW-1:0]     r_cur_addr;
  logic [CNT_W-1:0]     r_remaining;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_aborted;
  logic                 r_err;
  logic                 r_req;
  logic                 r_tag_valid;
  logic [INDEX_W-1:0]   r_addr_index;
  logic [TAG_W-1:0]     r_addr_tag;
  logic                 r_abort_pend;

  // Output buffer
  logic [63:0]          r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [OccW-1:0]      r_count;
  logic                 r_out_valid;

  logic                 w_discard;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_flush;
  logic [OccW-1:0]      w_count_next;
  logic                 w_has_room;
  logic [AddrW-1:0]     w_addr_next;

  // An abort seen in WAIT (now or earlier) turns the returning word into a discard.
  assign w_discard   = r_abort_pend | abort_i;
  assign w_push      = (r_state == StWait) & data_rvalid_i & ~w_discard;
  assign w_pop       = r_out_valid & out_ready_i;
  // Aborted runs flush the buffer on the same edge that raises done_o/aborted_o.
  assign w_flush     = ((r_state == StReq) & abort_i) |
                       ((r_state == StWait) & data_rvalid_i & w_discard) |
                       ((r_state == StDrainKill) & data_rvalid_i);
  assign w_addr_next = r_cur_addr + AddrW'(8);

  always_comb begin
    w_count_next = r_count;
    if (w_flush) begin
      w_count_next = '0;
    end else begin
      if (w_push) w_count_next = w_count_next + OccW'(1);
      if (w_pop)  w_count_next = w_count_next - OccW'(1);
    end
  end

  // Occupancy can only fall while in REQ, so judging room on the next-cycle count keeps
  // the registered request safe: a granted word always finds a free slot.
  assign w_has_room = (w_count_next < OccW'(FIFO_DEPTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_err        <= 1'b0;
      r_req        <= 1'b0;
      r_tag_valid  <= 1'b0;
      r_addr_index <= '0;
      r_addr_tag   <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // r_busy still high here means this is the done_o cycle: starts are refused.
          r_busy <= 1'b0;
          if (start_i && !r_busy) begin
            if (start_addr_i[2:0] != 3'b000) begin
              r_err <= 1'b1;
            end else begin
              r_busy <= 1'b1;
              if (num_words_i == '0) begin
                r_done <= 1'b1;
              end else begin
                r_cur_addr   <= start_addr_i;
                r_remaining  <= num_words_i;
                r_addr_index <= start_addr_i[INDEX_W-1:0];
                r_abort_pend <= 1'b0;
                r_req        <= w_has_room;
                r_state      <= StReq;
              end
            end
          end
        end
        StReq: begin
          if (abort_i) begin
            // A grant in this same cycle is ignored; no tag phase follows.
            r_req     <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= StIdle;
          end else if (r_req && data_gnt_i) begin
            r_req       <= 1'b0;
            r_tag_valid <= 1'b1;
            r_addr_tag  <= r_cur_addr[AddrW-1:INDEX_W];
            r_state     <= StTag;
          end else begin
            r_req <= w_has_room;
          end
        end
        StTag: begin
          r_tag_valid <= 1'b0;
          r_state     <= abort_i ? StDrainKill : StWait;
        end
        StWait: begin
          if (abort_i) r_abort_pend <= 1'b1;
          if (data_rvalid_i) begin
            if (w_discard) begin
              r_abort_pend <= 1'b0;
              r_done       <= 1'b1;
              r_aborted    <= 1'b1;
              r_state      <= StIdle;
            end else begin
              r_cur_addr  <= w_addr_next;
              r_remaining <= r_remaining - CNT_W'(1);
              if (r_remaining == CNT_W'(1)) begin
                r_done  <= 1'b1;
                r_state <= StIdle;
              end else begin
                r_addr_index <= w_addr_next[INDEX_W-1:0];
                r_req        <= w_has_room;
                r_state      <= StReq;
              end
            end
          end
        end
        StDrainKill: begin
          // The cache acknowledges the kill with one rvalid, which is dropped.
          if (data_rvalid_i) begin
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_rdata_i;
        r_wptr        <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
    end
  end

`ifdef DCACHE_WORD_READER_PERF_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;
  logic        w_start_ok;

  // Stalled: request pending without grant, or request held back by a full buffer.
  assign w_stall    = (r_state == StReq) & ~(r_req & data_gnt_i);
  assign w_start_ok = (r_state == StIdle) & ~r_busy & start_i & (start_addr_i[2:0] == 3'b000);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign err_o           = r_err;
  assign aborted_o       = r_aborted;
  assign address_index_o = r_addr_index;
  assign address_tag_o   = r_addr_tag;
  assign data_req_o      = r_req;
  assign tag_valid_o     = r_tag_valid;
  // The kill must accompany the tag phase it cancels, so it follows abort_i directly.
  assign kill_req_o      = (r_state == StTag) & abort_i;
  assign data_we_o       = 1'b0;
  assign data_be_o       = 8'hFF;
  assign data_size_o     = 2'b11;
  assign data_wdata_o    = '0;
  assign out_valid_o     = r_out_valid;
  assign out_data_o      = r_mem[r_rptr];

endmodule
